// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
// Two-requester front end for an external Booth multiplier. One operand pair
// is accepted at a time, issued with a single start pulse, and awaited with
// a timeout. The result is then returned to whichever requester owns the
// transaction. Ties go to the requester that was not granted last time.
module booth_mul_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,

    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,

    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [2*WIDTH-1:0] rsp_product,
    output logic               rsp_err,

    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,

    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t             state_q;
    state_t             state_d;
    logic               last_grant_q;
    logic               owner_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt_q;

    logic               grant_valid;
    logic               grant_id;
    logic               accept;
    logic               owner_rsp_ready;
    logic               wait_expired;

    // Arbitration: a lone requester wins outright, a tie goes to the one not granted last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant_q;
        end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    assign accept          = (state_q == IDLE) && grant_valid && !rst;
    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    assign wait_expired    = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mul_done only matters while waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid)                 state_d = ISSUE;
            ISSUE:                                    state_d = WAIT;
            WAIT:    if (mul_done || wait_expired)    state_d = RESP;
            RESP:    if (owner_rsp_ready)             state_d = IDLE;
            default:                                  state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state; reset masks every strobe in the same cycle.
    always_comb begin
        req0_ready = accept && (grant_id == 1'b0);
        req1_ready = accept && (grant_id == 1'b1);
        mul_start  = (state_q == ISSUE) && !rst;
        rsp0_valid = (state_q == RESP) && (owner_q == 1'b0) && !rst;
        rsp1_valid = (state_q == RESP) && (owner_q == 1'b1) && !rst;
        busy       = (state_q != IDLE);
        mul_a      = a_q;
        mul_b      = b_q;
    end

    // Transaction datapath: operand latch, ownership, wait counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            rsp_product  <= '0;
            rsp_err      <= 1'b0;
        end else begin
            if (accept) begin
                a_q          <= grant_id ? req1_a : req0_a;
                b_q          <= grant_id ? req1_b : req0_b;
                owner_q      <= grant_id;
                last_grant_q <= grant_id;
            end

            if (state_q == ISSUE) begin
                cnt_q <= '0;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + CW'(1);
            end

            if (state_q == WAIT) begin
                if (mul_done) begin
                    rsp_product <= mul_product;
                    rsp_err     <= 1'b0;
                end else if (wait_expired) begin
                    rsp_product <= '0;
                    rsp_err     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Testbench for booth_mul_arbiter. The bench plays both requesters and the
// multiplier. A small model tracks the round-robin rule and forms the
// expected product with plain signed arithmetic.
module tb_booth_mul_arbiter;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0_valid, req1_valid;
    logic [WIDTH-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic               req0_ready, req1_ready;
    logic               rsp0_valid, rsp1_valid;
    logic               rsp0_ready, rsp1_ready;
    logic [2*WIDTH-1:0] rsp_product;
    logic               rsp_err;
    logic               mul_start;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    bit m_last   = 1'b1;   // model of which requester was granted most recently

    booth_mul_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp_product (rsp_product),
        .rsp_err     (rsp_err),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One full transaction. Inputs change just after a falling edge and
    // outputs are sampled 1 ns later, well away from the rising edge.
    // k < 0 means the multiplier never answers.
    task automatic run_txn(input bit v0, input bit v1,
                           input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1,
                           input int k, input int hold,
                           input bit keep_other, input bit stray);
        bit                 w;
        bit                 exp_err;
        logic [7:0]         wa, wb;
        logic signed [15:0] exp_p;
        int                 lat;
        w       = (v0 && v1) ? ~m_last : v1;
        wa      = w ? a1 : a0;
        wb      = w ? b1 : b0;
        exp_err = (k < 0);
        exp_p   = exp_err ? 16'sd0 : $signed(wa) * $signed(wb);
        lat     = exp_err ? 2 + TIMEOUT : 2 + k;

        @(negedge clk);
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL accept_ready: got %b expected %b", {req1_ready, req0_ready}, (w ? 2'b10 : 2'b01));
        end
        m_last = w;

        @(negedge clk);
        req0_valid = keep_other && w;
        req1_valid = keep_other && !w;
        req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_a = 8'($urandom); req1_b = 8'($urandom);
        #1;
        checks++;
        if (mul_start !== 1'b1 || mul_a !== wa || mul_b !== wb || busy !== 1'b1 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL issue: start=%b a=%h b=%h busy=%b rdy=%b%b expected start=1 a=%h b=%h busy=1 rdy=00",
                     mul_start, mul_a, mul_b, busy, req1_ready, req0_ready, wa, wb);
        end

        for (int c = 2; c < lat; c++) begin
            @(negedge clk);
            mul_done    = !exp_err && (c == 1 + k);
            mul_product = mul_done ? exp_p : 16'($urandom);
            #1;
            checks++;
            if (mul_start !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
                mul_a !== wa || mul_b !== wb || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL wait[%0d]: start=%b rsp=%b%b a=%h b=%h rdy=%b%b expected start=0 rsp=00 a=%h b=%h rdy=00",
                         c, mul_start, rsp1_valid, rsp0_valid, mul_a, mul_b, req1_ready, req0_ready, wa, wb);
            end
        end

        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            mul_done    = stray && (h < hold);
            mul_product = 16'($urandom);
            rsp0_ready  = (h == hold) ? !w : (stray && w);
            rsp1_ready  = (h == hold) ? w  : (stray && !w);
            #1;
            checks++;
            if (rsp0_valid !== !w || rsp1_valid !== w || rsp_product !== exp_p ||
                rsp_err !== exp_err || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL resp[%0d]: rsp=%b%b prod=%h err=%b rdy=%b%b busy=%b expected rsp=%b%b prod=%h err=%b rdy=00 busy=1",
                         h, rsp1_valid, rsp0_valid, rsp_product, rsp_err, req1_ready, req0_ready, busy,
                         w, !w, exp_p, exp_err);
            end
        end

        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0; mul_done = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL release: busy=%b rsp=%b%b expected busy=0 rsp=00", busy, rsp1_valid, rsp0_valid);
        end
        if (keep_other) begin
            checks++;
            if ({req1_ready, req0_ready} !== (w ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL resume_ready: got %b expected %b", {req1_ready, req0_ready}, (w ? 2'b01 : 2'b10));
            end
        end
        // Withdraw before the rising edge so nothing is accepted here.
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; mul_done = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: rdy=%b%b expected 00", req1_ready, req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; mul_done = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || mul_start !== 1'b0 ||
            rsp_err !== 1'b0 || rsp_product !== 16'h0000 || mul_a !== 8'h00 || mul_b !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: busy=%b rsp=%b%b start=%b err=%b prod=%h a=%h b=%h expected all zero",
                     busy, rsp1_valid, rsp0_valid, mul_start, rsp_err, rsp_product, mul_a, mul_b);
        end
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic test_tie();
        // First tie after reset goes to requester 0, the next tie to requester 1.
        run_txn(1'b1, 1'b1, 8'h05, 8'h07, 8'hF0, 8'h11, 3, 0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b1, 8'h05, 8'h07, 8'hF0, 8'h11, 2, 1, 1'b0, 1'b0);
    endtask

    task automatic test_directed();
        run_txn(1'b1, 1'b0, 8'h03, 8'hFC, 8'h00, 8'h00, 8, 0, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        // Owner 0 stalls for 10 cycles while requester 1 waits and pokes rsp1_ready.
        run_txn(1'b1, 1'b0, 8'h80, 8'h7F, 8'h00, 8'h00, 4, 10, 1'b1, 1'b1);
        run_txn(1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h80, 1, 3, 1'b1, 1'b1);
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 1'b0, 8'h12, 8'h34, 8'h00, 8'h00, -1, 2, 1'b0, 1'b0);
        // A normal transaction afterwards must clear rsp_err again.
        run_txn(1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'hFF, 5, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            int r;
            r = int'($urandom_range(1, 3));
            run_txn(r[0], r[1], 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
                    1'b0, 1'($urandom));
        end
    endtask

    task automatic test_stray();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mul_done    = (i == 1);
            mul_product = 16'h1234;
            rsp1_ready  = (i == 2);
            rsp0_ready  = (i == 3);
            #1;
            checks++;
            if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || mul_start !== 1'b0) begin
                failures++;
                $display("FAIL stray_idle[%0d]: busy=%b rsp=%b%b start=%b expected 0 00 0",
                         i, busy, rsp1_valid, rsp0_valid, mul_start);
            end
        end
        mul_done = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        run_txn(1'b1, 1'b0, 8'hFE, 8'h03, 8'h00, 8'h00, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h21; req0_b = 8'h02;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_accept: req0_ready=%b expected 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mul_done    = (i == 1);
            mul_product = 16'h0042;
            #1;
            checks++;
            if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid[%0d]: busy=%b rsp=%b%b expected busy=0 rsp=00",
                         i, busy, rsp1_valid, rsp0_valid);
            end
        end
        mul_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Tie right after the mid-operation reset goes to requester 0 again.
        run_txn(1'b1, 1'b1, 8'h09, 8'hF7, 8'h44, 8'h02, 1, 0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b1, 8'h09, 8'hF7, 8'h44, 8'h02, 1, 0, 1'b0, 1'b0);
        run_txn(1'b1, 1'b1, 8'h7F, 8'h7F, 8'h80, 8'h01, 1, 0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        mul_done = 1'b0; mul_product = '0;

        test_reset();
        test_tie();
        test_directed();
        test_hold();
        test_timeout();
        test_random();
        test_stray();
        test_rst_mid();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand width; product width is 2*WIDTH.
REQ-002 Parameter: TIMEOUT, 64, maximum cycles in WAIT before abort.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid / req1_valid  input  1  requester N has an operand pair.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  signed multiplicand / multiplier of requester N.
REQ-007 req0_ready / req1_ready  output  1  arbiter accepts requester N this cycle.
REQ-008 rsp0_valid / rsp1_valid  output  1  result for requester N is presented.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester N consumes the result.
REQ-010 rsp_product  output  2*WIDTH  signed product, shared by both response ports.
REQ-011 rsp_err  output  1  result aborted by timeout; qualified by rspN_valid.
REQ-012 mul_start  output  1  one-cycle start pulse to the Booth multiplier.
REQ-013 mul_a, mul_b  output  WIDTH  operands driven to the multiplier.
REQ-014 mul_done  input  1  multiplier result valid pulse.
REQ-015 mul_product  input  2*WIDTH  multiplier result.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, encoded 2'd0..2'd3.
REQ-018 IDLE: if exactly one reqN_valid is high, reqN_ready SHALL be high combinationally for that requester in that cycle.
REQ-019 IDLE, both valid: grant SHALL go to the requester not recorded in last_grant; last_grant resets to 1, so requester 0 wins the first tie.
REQ-020 Only one reqN_ready SHALL be high in any cycle; ready SHALL be low in all states other than IDLE.
REQ-021 On acceptance, operands SHALL be latched into internal registers, owner ID recorded, last_grant updated, and the FSM SHALL move to ISSUE.
REQ-022 ISSUE: mul_start SHALL be high for exactly one cycle; FSM SHALL then go to WAIT.
REQ-023 mul_a/mul_b SHALL equal the latched operands from ISSUE through WAIT, held stable.
REQ-024 WAIT: on mul_done, mul_product SHALL be captured into rsp_product, rsp_err cleared, and the FSM SHALL go to RESP.
REQ-025 WAIT: a cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT-1 with no mul_done, the FSM SHALL go to RESP with rsp_product=0 and rsp_err=1.
REQ-026 mul_done in any state other than WAIT SHALL be ignored.
REQ-027 RESP: rspN_valid SHALL be high only for the owner; product and err SHALL be held until rspN_ready is high; the FSM then returns to IDLE.
REQ-028 rspN_ready for the non-owner, or in any state other than RESP, SHALL be ignored.
REQ-029 Latency: for acceptance at cycle T and mul_done at T+1+k, rspN_valid SHALL rise at T+2+k.
REQ-030 A new request SHALL not be accepted in the cycle the FSM leaves RESP; acceptance resumes the following cycle, in IDLE.
REQ-031 No arithmetic is performed; widths pass through unchanged.

Reset
REQ-032 rst SHALL force state=IDLE, last_grant=1, and counter, latched operands, and rsp_product to 0.
REQ-033 rst SHALL force rsp_err, mul_start, both reqN_ready, and both rspN_valid to 0.
REQ-034 rst mid-operation (ISSUE/WAIT/RESP) SHALL abandon the transaction with no response; a later mul_done SHALL be ignored.

Verification
REQ-035 req0 a=3, b=-4 alone; mul_done with 16'hFFF4 after 8 cycles -> req0_ready 1 cycle, mul_start 1 cycle, rsp0_valid with rsp_product=16'hFFF4, rsp_err=0.
REQ-036 Both valid in the same cycle after reset -> req0 served first, then req1; a second tie serves req1 first.
REQ-037 mul_done never asserted, TIMEOUT=64 -> rsp_err=1 and rsp_product=0 exactly 64 cycles after entering WAIT.
REQ-038 rsp0_ready held low 10 cycles in RESP -> rsp0_valid and product stable for 10 cycles; req1_valid held high gets no ready until RESP exits.
REQ-039 rst pulsed during WAIT, then mul_done pulsed -> busy=0 and no rspN_valid ever asserted.
REQ-040 Stray mul_done in IDLE and rsp1_ready while owner is 0 -> no state change and no response.
